// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter (one byte per request)
// Optional single retransmit on NACK/timeout when PS2_HOST_TX_RESEND_EN is defined.
module ps2_host_tx #(
    parameter int CLK_FREQ_HZ = 10_000_000,
    parameter int INHIBIT_US  = 100,
    parameter int TIMEOUT_US  = 15000
) (
    input  logic       clk_i,
    input  logic       resetn_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    input  logic       kclk_i,
    input  logic       kdata_i,
    output logic       kclk_oe_o,
    output logic       kdata_oe_o,
    output logic       done_o,
    output logic       err_o
);

    localparam int INHIBIT_CYC = CLK_FREQ_HZ / 1_000_000 * INHIBIT_US;
    localparam int TIMEOUT_CYC = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
    localparam int CW          = $clog2(TIMEOUT_CYC + 1);

    // The RTS cycle is the last inhibit cycle, so INHIBIT itself lasts one cycle less.
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYC - 2);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [3:0]    idx, idx_n;
    logic [7:0]    data_q, data_n;
    logic          par_q, par_n;
    logic          kclk_oe_q, kclk_n;
    logic          kdata_oe_q, kdata_n;
    logic          done_q, done_n;
    logic          err_q, err_n;
    logic          fail;
    logic          ready;
`ifdef PS2_HOST_TX_RESEND_EN
    logic          retry_q, retry_n;
`endif

    logic kclk_s1, kclk_s2, kclk_d;
    logic kdata_s1, kdata_s2;
    logic kclk_fall;
    logic tmo_hit;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            kclk_s1  <= 1'b1;
            kclk_s2  <= 1'b1;
            kclk_d   <= 1'b1;
            kdata_s1 <= 1'b1;
            kdata_s2 <= 1'b1;
        end else begin
            kclk_s1  <= kclk_i;
            kclk_s2  <= kclk_s1;
            kclk_d   <= kclk_s2;
            kdata_s1 <= kdata_i;
            kdata_s2 <= kdata_s1;
        end
    end

    assign kclk_fall = kclk_d & ~kclk_s2;
    assign tmo_hit   = (cnt == TMO_LAST);
    assign cnt_inc   = (cnt < TMO_LAST) ? cnt + CW'(1) : cnt;
    // Hold ready low during the pulse cycle so it rises the cycle after done/err.
    assign ready     = (state == S_IDLE) && !done_q && !err_q;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state      <= S_IDLE;
            cnt        <= '0;
            idx        <= '0;
            data_q     <= '0;
            par_q      <= 1'b0;
            kclk_oe_q  <= 1'b0;
            kdata_oe_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef PS2_HOST_TX_RESEND_EN
            retry_q    <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            data_q     <= data_n;
            par_q      <= par_n;
            kclk_oe_q  <= kclk_n;
            kdata_oe_q <= kdata_n;
            done_q     <= done_n;
            err_q      <= err_n;
`ifdef PS2_HOST_TX_RESEND_EN
            retry_q    <= retry_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        data_n  = data_q;
        par_n   = par_q;
        kclk_n  = kclk_oe_q;
        kdata_n = kdata_oe_q;
        done_n  = 1'b0;
        err_n   = 1'b0;
        fail    = 1'b0;
`ifdef PS2_HOST_TX_RESEND_EN
        retry_n = retry_q;
`endif

        case (state)
            S_IDLE: begin
                kclk_n  = 1'b0;
                kdata_n = 1'b0;
                if (valid_i && ready) begin
                    data_n  = data_i;
                    par_n   = ~^data_i;
                    cnt_n   = '0;
                    kclk_n  = 1'b1;
                    state_n = S_INHIBIT;
`ifdef PS2_HOST_TX_RESEND_EN
                    retry_n = 1'b0;
`endif
                end
            end
            S_INHIBIT: begin
                kclk_n = 1'b1;
                if (cnt == INH_LAST) begin
                    kdata_n = 1'b1;
                    cnt_n   = '0;
                    state_n = S_RTS;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            S_RTS: begin
                kclk_n  = 1'b0;
                cnt_n   = '0;
                idx_n   = '0;
                state_n = S_SEND;
            end
            S_SEND: begin
                cnt_n = cnt_inc;
                if (kclk_fall) begin
                    idx_n = idx + 4'd1;
                    if (idx < 4'd8) begin
                        kdata_n = ~data_q[idx[2:0]];
                    end else if (idx == 4'd8) begin
                        kdata_n = ~par_q;
                    end else begin
                        kdata_n = 1'b0;
                        state_n = S_ACK;
                    end
                end else if (tmo_hit) begin
                    fail = 1'b1;
                end
            end
            S_ACK: begin
                cnt_n = cnt_inc;
                // An ack edge takes priority over a coinciding timeout and restarts the budget.
                if (kclk_fall) begin
                    if (!kdata_s2) begin
                        cnt_n   = '0;
                        state_n = S_WAIT_IDLE;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (tmo_hit) begin
                    fail = 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                cnt_n = cnt_inc;
                if (kclk_s2 && kdata_s2) begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else if (tmo_hit) begin
                    fail = 1'b1;
                end
            end
            default: begin
                kclk_n  = 1'b0;
                kdata_n = 1'b0;
                state_n = S_IDLE;
            end
        endcase

        if (fail) begin
            kclk_n  = 1'b0;
            kdata_n = 1'b0;
            err_n   = 1'b1;
            state_n = S_IDLE;
`ifdef PS2_HOST_TX_RESEND_EN
            if (!retry_q) begin
                retry_n = 1'b1;
                err_n   = 1'b0;
                kclk_n  = 1'b1;
                cnt_n   = '0;
                state_n = S_INHIBIT;
            end
`endif
        end
    end

    assign ready_o    = ready;
    assign kclk_oe_o  = kclk_oe_q;
    assign kdata_oe_o = kdata_oe_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with a behavioural PS/2 device
module tb_ps2_host_tx;

    localparam int INH  = 1000;
    localparam int TMO  = 20000;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       kclk_oe, kdata_oe;
    logic       done, err;
    logic       dev_clk_low, dev_data_low;
    logic       kclk_line, kdata_line;

    assign kclk_line  = ~(kclk_oe | dev_clk_low);
    assign kdata_line = ~(kdata_oe | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .CLK_FREQ_HZ(10_000_000),
        .INHIBIT_US (100),
        .TIMEOUT_US (2000)
    ) dut (
        .clk_i     (clk),
        .resetn_i  (resetn),
        .data_i    (data),
        .valid_i   (valid),
        .ready_o   (ready),
        .kclk_i    (kclk_line),
        .kdata_i   (kdata_line),
        .kclk_oe_o (kclk_oe),
        .kdata_oe_o(kdata_oe),
        .done_o    (done),
        .err_o     (err)
    );

    typedef struct {
        logic [7:0] d;
        bit         exp_done;
        bit         chk;
        int         nfr;
    } exp_t;

    exp_t       exp_q[$];
    logic [9:0] obs_q[$];

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   release_cyc = 0;
    int   hi_run      = 0;
    logic prev_kclk_oe = 1'b0;
    bit   pend        = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Frame as the device sees it, LSB first: 8 data bits, odd parity, stop bit high.
    function automatic logic [9:0] ref_frame(input logic [7:0] d);
        logic par;
        par = (($countones(d) % 2) == 0);
        return {1'b1, par, d};
    endfunction

    function automatic int frames_for(input bit ack_ok);
`ifdef PS2_HOST_TX_RESEND_EN
        return ack_ok ? 1 : 2;
`else
        return 1;
`endif
    endfunction

    task automatic monitor();
        exp_t       e;
        logic [9:0] f;
        forever begin
            @(negedge clk);
            if (cyc > 95000) begin
                $display("FAIL watchdog: cycle %0d exceeded budget", cyc);
                $fatal(1);
            end
            if (kclk_oe) begin
                hi_run++;
            end else begin
                if (prev_kclk_oe && resetn) begin
                    release_cyc = cyc;
                    check("inhibit_len", hi_run, INH);
                    check("start_bit_driven", kdata_oe, 1);
                end
                hi_run = 0;
            end
            prev_kclk_oe = kclk_oe;
            if (pend) begin
                pend = 1'b0;
                check("post_pulse_quiet", {done, err}, 0);
                check("ready_after_pulse", ready, 1);
            end
            if (resetn && (done || err)) begin
                pend = 1'b1;
                check("done_err_exclusive", done & err, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {done, err}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("outcome_done", done, e.exp_done);
                    if (err) check("lines_released_on_err", {kclk_oe, kdata_oe}, 0);
                    if (e.chk) begin
                        for (int i = 0; i < e.nfr; i++) begin
                            if (obs_q.size() == 0) begin
                                check("frame_missing", 1, 0);
                            end else begin
                                f = obs_q.pop_front();
                                check("frame_bits", f, ref_frame(e.d));
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic wait_ready_push(input logic [7:0] d, input bit exp_done, input bit chk, input int nfr);
        exp_t e;
        int   n;
        n = 0;
        while (!ready && n < 50000) begin
            @(negedge clk);
            n++;
        end
        check("ready_seen", ready, 1);
        e.d = d; e.exp_done = exp_done; e.chk = chk; e.nfr = nfr;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [7:0] d, input bit exp_done, input bit chk, input int nfr);
        @(negedge clk);
        data  = d;
        valid = 1'b1;
        wait_ready_push(d, exp_done, chk, nfr);
        @(negedge clk);
        valid = 1'b0;
        data  = $urandom;
    endtask

    task automatic dev_frame(input bit ack_ok, input int nedges, input bit coincide);
        logic [9:0] fr;
        bit         seen_hi;
        int         n;
        fr = '0;
        seen_hi = 1'b0;
        n = 0;
        while (n < 5000 && !(seen_hi && !kclk_oe)) begin
            @(negedge clk);
            if (kclk_oe) seen_hi = 1'b1;
            n++;
        end
        if (n >= 5000) begin
            check("release_seen", 0, 1);
            return;
        end
        repeat (5) @(negedge clk);
        for (int k = 1; k <= nedges; k++) begin
            if (k == 11 && ack_ok) dev_data_low = 1'b1;
            if (k == 11 && coincide) begin
                // Third posedge after this negedge is the host's terminal timeout cycle.
                while (cyc < release_cyc + TMO - 3) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            if (k <= 10) fr[k-1] = kdata_line;
            dev_clk_low = 1'b0;
            if (k == 10) obs_q.push_back(fr);
        end
        if (nedges == 11) repeat (HALF) @(negedge clk);
        dev_data_low = 1'b0;
    endtask

    task automatic wait_quiet();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3 * TMO + 3 * INH; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && ready && !pend) begin
                ok = 1'b1;
                break;
            end
        end
        check("transfer_completed", ok, 1);
    endtask

    task automatic run_xfer(input logic [7:0] d, input bit ack_ok);
        int nfr;
        nfr = frames_for(ack_ok);
        issue(d, ack_ok, 1'b1, nfr);
        for (int f = 0; f < nfr; f++) dev_frame(ack_ok, 11, 1'b0);
        wait_quiet();
    endtask

    initial begin
        logic [7:0] rd;
        bit         rack;
        resetn       = 1'b0;
        valid        = 1'b0;
        data         = 8'h00;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        fork
            monitor();
        join_none
        repeat (5) @(negedge clk);
        check("reset_ready", ready, 1);
        check("reset_oe", {kclk_oe, kdata_oe}, 0);
        check("reset_pulses", {done, err}, 0);
        resetn = 1'b1;
        @(negedge clk);

        // Reset in the middle of SEND, after four device clock edges (bit 3 of 0x35 is 0).
        issue(8'h35, 1'b1, 1'b1, 1);
        dev_frame(1'b1, 4, 1'b0);
        check("pre_reset_kdata_oe", kdata_oe, 1);
        #3 resetn = 1'b0;
        #1 check("async_release", {kclk_oe, kdata_oe, ready}, 3'b001);
        exp_q.delete();
        obs_q.delete();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (100) @(negedge clk);

        run_xfer(8'hED, 1'b1);
        run_xfer(8'h07, 1'b0);

        // Device never clocks: error exactly TMO cycles after the clock is released.
        issue(8'h5A, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3 * TMO && !err; i++) @(negedge clk);
        check("timeout_err_seen", err, 1);
        check("timeout_latency", cyc - release_cyc, TMO);
        wait_quiet();

        // valid held with 0xFF while 0xED is in flight.
        @(negedge clk);
        data  = 8'hED;
        valid = 1'b1;
        wait_ready_push(8'hED, 1'b1, 1'b1, 1);
        @(negedge clk);
        data = 8'hFF;
        dev_frame(1'b1, 11, 1'b0);
        @(negedge clk);
        wait_ready_push(8'hFF, 1'b1, 1'b1, 1);
        @(negedge clk);
        valid = 1'b0;
        dev_frame(1'b1, 11, 1'b0);
        wait_quiet();

        // Ack edge lands on the timeout terminal count.
        issue(8'hA5, 1'b1, 1'b1, 1);
        dev_frame(1'b1, 11, 1'b1);
        wait_quiet();

        for (int t = 0; t < 10; t++) begin
            rd   = 8'($urandom);
            rack = ($urandom_range(0, 3) != 0);
            run_xfer(rd, rack);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
